// File: rtl/alerta_farois_if.sv
// ============================================================================
// Module   : alerta_farois_if
// Brief    : Switch-side and driver-side signal bundle for alerta_farois.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alerta_farois_if #(
  parameter int N_FAROIS = 2
);
  logic [N_FAROIS-1:0] farol;
  logic                porta;
  logic                chave;
  logic                confirma;
  logic                sinalizador;
  logic                buzina;
  logic [N_FAROIS-1:0] desliga;
  logic [1:0]          estado;

  modport master (
    output farol, porta, chave, confirma,
    input  sinalizador, buzina, desliga, estado
  );

  modport slave (
    input  farol, porta, chave, confirma,
    output sinalizador, buzina, desliga, estado
  );
endinterface

`default_nettype wire

// File: rtl/alerta_farois.sv
// ============================================================================
// Module   : alerta_farois
// Brief    : Headlight warning controller: debounced door/key, pulsed buzzer,
//            optional timed auto-off (enabled by defining AUTO_DESLIGA_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alerta_farois #(
  parameter int N_FAROIS        = 2,
  parameter int DEBOUNCE_CICLOS = 4,
  parameter int T_AVISO         = 16,
  parameter int BIP_CICLOS      = 2
) (
  input  wire logic      clock,
  input  wire logic      reset,
  alerta_farois_if.slave bus
);

  localparam int c_DEB_W  = $clog2(DEBOUNCE_CICLOS + 1);
  localparam int c_BEEP_W = $clog2(2 * BIP_CICLOS);
  localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEBOUNCE_CICLOS - 1);
  localparam logic [c_BEEP_W-1:0] c_BEEP_LAST = c_BEEP_W'(2 * BIP_CICLOS - 1);
  localparam logic [c_BEEP_W-1:0] c_BEEP_HALF = c_BEEP_W'(BIP_CICLOS);
`ifdef AUTO_DESLIGA_EN
  localparam int c_TIMER_W = $clog2(T_AVISO);
  localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(T_AVISO - 1);
`endif

  typedef enum logic [1:0] {
    S_OCIOSO     = 2'd0,
    S_AVISO      = 2'd1,
    S_DESLIGANDO = 2'd2,
    S_SILENCIADO = 2'd3
  } estado_t;

  generate
    if (N_FAROIS < 1 || N_FAROIS > 8 || DEBOUNCE_CICLOS < 1 ||
        T_AVISO < 2 || BIP_CICLOS < 1) begin : g_param_err
      $error("alerta_farois: parameter out of range");
    end
  endgenerate

  logic [N_FAROIS-1:0] r_farol;
  logic [1:0]          w_raw;
  logic [1:0]          w_filt;
  logic                w_cond;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_farol <= '0;
    end else begin
      r_farol <= bus.farol;
    end
  end

  assign w_raw = {bus.chave, bus.porta};

  // Index 0 filters the door contact, index 1 the key contact.
  generate
    for (genvar i = 0; i < 2; i++) begin : g_deb
      logic               r_filt;
      logic [c_DEB_W-1:0] r_cnt;

      always_ff @(posedge clock) begin
        if (reset) begin
          r_filt <= 1'b1;
          r_cnt  <= '0;
        end else if (w_raw[i] == r_filt) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DEB_LAST) begin
          r_filt <= w_raw[i];
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_filt[i] = r_filt;
    end
  endgenerate

  assign w_cond = (|r_farol) & ~(w_filt[0] & w_filt[1]);

  estado_t             r_estado, w_estado_nxt;
  logic [c_BEEP_W-1:0] r_beep, w_beep_nxt;
`ifdef AUTO_DESLIGA_EN
  logic [c_TIMER_W-1:0] r_timer, w_timer_nxt;
  logic [N_FAROIS-1:0]  r_mask, w_mask_nxt;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= S_OCIOSO;
      r_beep   <= '0;
`ifdef AUTO_DESLIGA_EN
      r_timer  <= '0;
      r_mask   <= '0;
`endif
    end else begin
      r_estado <= w_estado_nxt;
      r_beep   <= w_beep_nxt;
`ifdef AUTO_DESLIGA_EN
      r_timer  <= w_timer_nxt;
      r_mask   <= w_mask_nxt;
`endif
    end
  end

  always_comb begin
    w_estado_nxt = r_estado;
    w_beep_nxt   = r_beep;
`ifdef AUTO_DESLIGA_EN
    w_timer_nxt  = r_timer;
    w_mask_nxt   = r_mask;
`endif
    case (r_estado)
      S_OCIOSO: begin
        if (w_cond) begin
          w_estado_nxt = S_AVISO;
          w_beep_nxt   = '0;
`ifdef AUTO_DESLIGA_EN
          w_timer_nxt  = '0;
`endif
        end
      end
      S_AVISO: begin
        if (!w_cond) begin
          w_estado_nxt = S_OCIOSO;
        end else if (bus.confirma) begin
          w_estado_nxt = S_SILENCIADO;
`ifdef AUTO_DESLIGA_EN
        end else if (r_timer == c_TIMER_LAST) begin
          w_estado_nxt = S_DESLIGANDO;
          w_mask_nxt   = r_farol;
`endif
        end else begin
`ifdef AUTO_DESLIGA_EN
          w_timer_nxt = r_timer + 1'b1;
`endif
          w_beep_nxt = (r_beep == c_BEEP_LAST) ? '0 : r_beep + 1'b1;
        end
      end
      S_DESLIGANDO: begin
        w_estado_nxt = S_SILENCIADO;
      end
      S_SILENCIADO: begin
        if (!w_cond) begin
          w_estado_nxt = S_OCIOSO;
        end
      end
      default: begin
        w_estado_nxt = S_OCIOSO;
      end
    endcase
  end

  assign bus.estado      = r_estado;
  assign bus.sinalizador = (r_estado != S_OCIOSO);
  assign bus.buzina      = (r_estado == S_AVISO) && (r_beep < c_BEEP_HALF);
`ifdef AUTO_DESLIGA_EN
  assign bus.desliga     = (r_estado == S_DESLIGANDO) ? r_mask : '0;
`else
  assign bus.desliga     = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alerta_farois.sv
// ============================================================================
// Module   : tb_alerta_farois
// Brief    : Directed self-checking bench for alerta_farois (both builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alerta_farois;

  logic clock = 1'b0;
  logic reset;
  int   passed = 0;
  int   fails  = 0;
  int   total  = 0;

  alerta_farois_if #(.N_FAROIS(2)) bus ();

  alerta_farois #(
    .N_FAROIS        (2),
    .DEBOUNCE_CICLOS (4),
    .T_AVISO         (16),
    .BIP_CICLOS      (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic s, input logic b,
                         input logic [1:0] d, input logic [1:0] e);
    chk({tag, ".sinalizador"}, bus.sinalizador, s);
    chk({tag, ".buzina"},      bus.buzina,      b);
    chk({tag, ".desliga"},     bus.desliga,     d);
    chk({tag, ".estado"},      bus.estado,      e);
  endtask

  initial begin
    // Reset with arbitrary alarm-like inputs
    reset = 1'b1;
    bus.farol = 2'b11; bus.porta = 1'b0; bus.chave = 1'b0; bus.confirma = 1'b1;
    tick(2);
    chk_all("reset", 1'b0, 1'b0, 2'b00, 2'd0);

    reset = 1'b0;
    bus.farol = 2'b00; bus.porta = 1'b1; bus.chave = 1'b1; bus.confirma = 1'b0;
    tick(2);
    chk_all("idle", 1'b0, 1'b0, 2'b00, 2'd0);

    // Door glitch shorter than the debounce window
    bus.farol = 2'b11;
    tick(2);
    bus.porta = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("glitch.estado", bus.estado, 2'd0);
    end
    bus.porta = 1'b1;
    tick(4);
    chk("glitch.estado_after", bus.estado, 2'd0);
    chk("glitch.sinalizador", bus.sinalizador, 1'b0);

    // Door opens and stays open: filtered after 4 edges, AVISO one edge later
    bus.farol = 2'b01;
    bus.porta = 1'b0;
    tick(4);
    chk("deb.estado_edge4", bus.estado, 2'd0);
    tick();
    chk("aviso.entry", bus.estado, 2'd1);

`ifdef AUTO_DESLIGA_EN
    for (int i = 0; i < 16; i++) begin
      chk("aviso.estado", bus.estado, 2'd1);
      chk("aviso.buzina", bus.buzina, ((i % 4) < 2) ? 1'b1 : 1'b0);
      chk("aviso.desliga", bus.desliga, 2'b00);
      tick();
    end
    chk_all("desligando", 1'b1, 1'b0, 2'b01, 2'd2);
    tick();
    chk_all("silenciado", 1'b1, 1'b0, 2'b00, 2'd3);
    tick();
    chk("silenciado.hold", bus.estado, 2'd3);
`else
    for (int i = 0; i < 40; i++) begin
      chk("noauto.estado", bus.estado, 2'd1);
      chk("noauto.buzina", bus.buzina, ((i % 4) < 2) ? 1'b1 : 1'b0);
      chk("noauto.desliga", bus.desliga, 2'b00);
      tick();
    end
`endif

    // Headlights off: registered farol, then state follows
    bus.farol = 2'b00;
    tick();
    chk("farol_off.lag", bus.sinalizador, 1'b1);
    tick();
    chk_all("farol_off", 1'b0, 1'b0, 2'b00, 2'd0);

    // Acknowledge in AVISO, then close the door
    bus.farol = 2'b10;
    tick(2);
    chk("ack.aviso", bus.estado, 2'd1);
    chk("ack.buzina0", bus.buzina, 1'b1);
    tick();
    bus.confirma = 1'b1;
    tick();
    chk_all("ack.silenciado", 1'b1, 1'b0, 2'b00, 2'd3);
    bus.confirma = 1'b0;
    bus.porta = 1'b1;
    tick(4);
    chk("ack.door_filtering", bus.estado, 2'd3);
    tick();
    chk_all("ack.closed", 1'b0, 1'b0, 2'b00, 2'd0);

    // cond drop outranks confirma in the same AVISO cycle
    bus.porta = 1'b0;
    tick(5);
    chk("prio.aviso", bus.estado, 2'd1);
    bus.farol = 2'b00;
    tick();
    chk("prio.still_aviso", bus.estado, 2'd1);
    bus.confirma = 1'b1;
    tick();
    chk("prio.ocioso", bus.estado, 2'd0);
    bus.confirma = 1'b0;

    // Reset pulse mid-AVISO restores filtered door to closed
    bus.farol = 2'b11;
    tick(2);
    chk("rst.aviso", bus.estado, 2'd1);
    tick();
    reset = 1'b1;
    tick();
    chk_all("rst.mid", 1'b0, 1'b0, 2'b00, 2'd0);
    reset = 1'b0;
    tick(4);
    chk("rst.refilter", bus.estado, 2'd0);
    tick();
    chk("rst.realarm", bus.estado, 2'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
